memalu_arbiter: RTL and testbench
=================================

# memalu_arbiter

Sequencer and round-robin arbiter for the shared 16-bit memory-address ALU (MEMALU). It accepts address-arithmetic requests from three clients and drives MEMALU's operand, mode and `reg_op_t` control inputs through a read-then-write sequence:

- port 0: fetch PC increment
- port 1: stack-pointer push/pop
- port 2: relative/indexed address generation

It captures the result from the shared bus and returns it to the winning client with a one-cycle done pulse.

## Interface
Parameters:
- HALF_WIDTH, 8, datapath half-width; addresses are 2*HALF_WIDTH bits.

Ports:
- clk  in  1  system clock; all arbiter state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  3  per-port request, level; held high until that port's done.
- req_a  in  3 × 2*HALF_WIDTH  per-port operand A.
- req_b  in  3 × HALF_WIDTH  per-port operand B.
- req_mode  in  3 × memalu_op_t  per-port operation.
- grant  out  3  one-hot; winner's bit high from LOAD through RESP.
- done  out  3  one-hot, one-cycle pulse in RESP.
- result  out  2*HALF_WIDTH  last captured ALU result; holds until the next capture.
- busy  out  1  high in any state other than IDLE.
- alu_a  out  2*HALF_WIDTH  to MEMALU a.
- alu_b  out  HALF_WIDTH  to MEMALU b.
- alu_mode  out  memalu_op_t  to MEMALU mode.
- alu_control  out  reg_op_t  to MEMALU control.
- alu_out  in  2*HALF_WIDTH  shared result bus, driven by MEMALU during REG_OP_WRITE.
- bus_ok  in  1  shared bus free this cycle; MEMALU may drive it.

## Operation
- States: IDLE, LOAD, EXEC, RESP.
- IDLE
  - alu_control = REG_OP_NONE.
  - If any req is high: pick the winner round-robin, starting at the port after `last`.
  - Register the winner's a, b and mode into alu_a/alu_b/alu_mode, set grant, go to LOAD.
- LOAD
  - alu_control = REG_OP_READ; MEMALU latches operands on this cycle's negedge.
  - Next state is always EXEC.
- EXEC
  - alu_control = bus_ok ? REG_OP_WRITE : REG_OP_NONE (combinational on bus_ok).
  - At a posedge with bus_ok high: result <= alu_out, go to RESP.
  - Otherwise stay in EXEC. MEMALU's latched operands are retained because control is not READ.
- RESP
  - done[winner] = 1; `last` <= winner; alu_control = REG_OP_NONE.
  - The winner's req is ignored this cycle.
  - If any other req is high: arbitrate (pointer already advanced past the winner), capture operands, go directly to LOAD with the new grant.
  - Otherwise go to IDLE and clear grant.
- Operands are sampled only at grant. A requester may change req_a/req_b/req_mode after grant rises, but must keep req high until done.
- Requester handshake: deassert req, or present a new operation, on the posedge ending the done cycle.
- Arithmetic is entirely inside MEMALU; result is modulo 2^(2*HALF_WIDTH). The arbiter passes it through unmodified.
- Reset (any state, including mid-EXEC):
  - state IDLE; grant = 0; done = 0; busy = 0.
  - alu_control = REG_OP_NONE; alu_a = 0; alu_b = 0; alu_mode = MEMALU_OP_ADD.
  - result = 0; `last` = 2, so port 0 wins first.
  - An aborted operation produces no done.

## Timing
- Latency from req sampled in IDLE to done: 3 cycles (LOAD, EXEC, RESP), plus one cycle per cycle bus_ok is low in EXEC.
- Back-to-back throughput with contention: one completion per 3 cycles (RESP → LOAD).
- Fairness: with all three ports continuously requesting, each port completes once per 9 cycles. No port waits longer than 2 other operations.
- REG_OP_READ and REG_OP_WRITE are never asserted in the same cycle or in adjacent cycles for different winners without an intervening LOAD.
- Outputs are registered except alu_control in EXEC.

## Test plan
- Single OFFSET, port 2: a=0x1000, b=0x05, idle bus → grant[2] at cycle 1, done[2] at cycle 3, result=0x0F85.
- Wrap cases: port 0 INCR a=0xFFFF → 0x0000; port 1 DECR a=0x0000 → 0xFFFF; ADD a=0xFFF0, b=0x20 → 0x0010.
- Contention: all req high from cycle 0 after reset → done order 0, 1, 2 at cycles 3, 6, 9. Re-asserting port 0 at cycle 4 gives it service only after port 2.
- Bus stall: bus_ok low for 2 cycles on entering EXEC → alu_control = REG_OP_NONE during the stall, no WRITE, done delayed to cycle 5, correct result.
- Reset mid-EXEC: rst at cycle 2 → next cycle is IDLE with all outputs at reset values and no done. A subsequent request completes normally.
- Operand change after grant: modify req_a at cycle 2 → result reflects the value sampled at grant.

Source files
------------

// File: rtl/memalu_arbiter_if.sv
// rtl/memalu_arbiter_if.sv - MEMALU operation types and the arbiter client/ALU bus interface
package memalu_pkg;
  typedef enum logic [1:0] {
    MEMALU_OP_ADD,
    MEMALU_OP_INCR,
    MEMALU_OP_DECR,
    MEMALU_OP_OFFSET
  } memalu_op_t;

  typedef enum logic [1:0] {
    REG_OP_NONE,
    REG_OP_READ,
    REG_OP_WRITE
  } reg_op_t;
endpackage

interface memalu_arbiter_if #(
  parameter int HALF_WIDTH = 8
);
  import memalu_pkg::*;
  localparam int AW = 2 * HALF_WIDTH;

  logic [2:0]                 req;
  logic [2:0][AW-1:0]         req_a;
  logic [2:0][HALF_WIDTH-1:0] req_b;
  memalu_op_t [2:0]           req_mode;
  logic [2:0]                 grant;
  logic [2:0]                 done;
  logic [AW-1:0]              result;
  logic                       busy;
  logic [AW-1:0]              alu_a;
  logic [HALF_WIDTH-1:0]      alu_b;
  memalu_op_t                 alu_mode;
  reg_op_t                    alu_control;
  logic [AW-1:0]              alu_out;
  logic                       bus_ok;

  modport master (
    output req, req_a, req_b, req_mode, alu_out, bus_ok,
    input  grant, done, result, busy, alu_a, alu_b, alu_mode, alu_control
  );

  modport slave (
    input  req, req_a, req_b, req_mode, alu_out, bus_ok,
    output grant, done, result, busy, alu_a, alu_b, alu_mode, alu_control
  );
endinterface

// File: rtl/memalu_arbiter.sv
// rtl/memalu_arbiter.sv - round-robin sequencer sharing one MEMALU among three address clients
module memalu_arbiter
  import memalu_pkg::*;
#(
  parameter int HALF_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  memalu_arbiter_if.slave bus
);
  localparam int AW = 2 * HALF_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [2:0]            grant_q, done_q;
  logic [1:0]            last_q, win_q;
  logic                  busy_q;
  logic [AW-1:0]         result_q, alu_a_q;
  logic [HALF_WIDTH-1:0] alu_b_q;
  memalu_op_t            alu_mode_q;
  reg_op_t               alu_control;

  logic [1:0] ptr, o0, o1, o2, pick;
  logic [2:0] cand;
  logic       pick_valid, load;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // In RESP the pointer is the current winner, whose request is masked out.
  always_comb begin
    ptr        = (state_q == S_RESP) ? win_q : last_q;
    cand       = (state_q == S_RESP) ? (bus.req & ~grant_q) : bus.req;
    o0         = next_port(ptr);
    o1         = next_port(o0);
    o2         = next_port(o1);
    pick_valid = 1'b0;
    pick       = 2'd0;
    if (cand[o2]) begin pick_valid = 1'b1; pick = o2; end
    if (cand[o1]) begin pick_valid = 1'b1; pick = o1; end
    if (cand[o0]) begin pick_valid = 1'b1; pick = o0; end
  end

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    alu_control = REG_OP_NONE;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_LOAD;
          load    = 1'b1;
        end
      end
      S_LOAD: begin
        alu_control = REG_OP_READ;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        if (bus.bus_ok) begin
          alu_control = REG_OP_WRITE;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (pick_valid) begin
          state_d = S_LOAD;
          load    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      last_q     <= 2'd2;
      win_q      <= 2'd0;
      result_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_mode_q <= MEMALU_OP_ADD;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q == S_EXEC && bus.bus_ok) ? grant_q : 3'b000;
      if (state_q == S_EXEC && bus.bus_ok) begin
        result_q <= bus.alu_out;
      end
      if (state_q == S_RESP) begin
        last_q <= win_q;
      end
      if (load) begin
        win_q      <= pick;
        grant_q    <= 3'b001 << pick;
        alu_a_q    <= bus.req_a[pick];
        alu_b_q    <= bus.req_b[pick];
        alu_mode_q <= bus.req_mode[pick];
      end else if (state_d == S_IDLE) begin
        grant_q <= '0;
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.result      = result_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_mode    = alu_mode_q;
  assign bus.alu_control = alu_control;
endmodule

// File: tb/tb_memalu_arbiter.sv
// tb/tb_memalu_arbiter.sv - self-checking bench for memalu_arbiter with a MEMALU model and round-robin reference
module tb_memalu_arbiter;
  import memalu_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  memalu_arbiter_if #(.HALF_WIDTH(8)) bus ();

  memalu_arbiter #(.HALF_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [7:0] b, input memalu_op_t m);
    case (m)
      MEMALU_OP_ADD:    return a + {8'h00, b};
      MEMALU_OP_INCR:   return a + 16'h0001;
      MEMALU_OP_DECR:   return a - 16'h0001;
      default:          return a + {8'h00, b} - 16'h0080;
    endcase
  endfunction

  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    for (int k = 1; k <= 3; k++) begin
      int p;
      p = (int'(last) + k) % 3;
      if (r[p]) return 3'(1 << p);
    end
    return 3'b000;
  endfunction

  // MEMALU stand-in: latches operands on the READ negedge, drives the bus only on WRITE.
  logic [15:0] m_a;
  logic [7:0]  m_b;
  memalu_op_t  m_mode;
  always @(negedge clk) begin
    if (bus.alu_control == REG_OP_READ) begin
      m_a    <= bus.alu_a;
      m_b    <= bus.alu_b;
      m_mode <= bus.alu_mode;
    end
  end
  always_comb bus.alu_out = (bus.alu_control == REG_OP_WRITE) ? alu_f(m_a, m_b, m_mode) : 16'hBAD0;

  logic [15:0] cur_a [3];
  logic [7:0]  cur_b [3];
  memalu_op_t  cur_m [3];

  task automatic present_op(input int p);
    cur_a[p] = 16'($urandom);
    cur_b[p] = 8'($urandom);
    cur_m[p] = memalu_op_t'($urandom_range(0, 3));
    bus.req_a[p]    = cur_a[p];
    bus.req_b[p]    = cur_b[p];
    bus.req_mode[p] = cur_m[p];
    bus.req[p]      = 1'b1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.req = 3'b000;
    bus.bus_ok = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_single(input int p, input logic [15:0] a, input logic [7:0] b, input memalu_op_t m,
                            output logic [15:0] res, output int lat);
    @(negedge clk);
    bus.req_a[p] = a; bus.req_b[p] = b; bus.req_mode[p] = m; bus.req[p] = 1'b1;
    lat = -1; res = 16'hxxxx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (bus.done[p]) begin
        lat = k; res = bus.result;
        break;
      end
    end
    bus.req[p] = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    n_cmp++; if (bus.grant !== 3'b000) begin n_err++; $display("FAIL reset_grant got %b want 000", bus.grant); end
    n_cmp++; if (bus.done !== 3'b000) begin n_err++; $display("FAIL reset_done got %b want 000", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.alu_control !== REG_OP_NONE) begin n_err++; $display("FAIL reset_ctl got %0d want NONE", bus.alu_control); end
    n_cmp++; if (bus.alu_a !== 16'h0 || bus.alu_b !== 8'h0) begin n_err++; $display("FAIL reset_operands got %h/%h want 0/0", bus.alu_a, bus.alu_b); end
    n_cmp++; if (bus.alu_mode !== MEMALU_OP_ADD) begin n_err++; $display("FAIL reset_mode got %0d want ADD", bus.alu_mode); end
    n_cmp++; if (bus.result !== 16'h0) begin n_err++; $display("FAIL reset_result got %h want 0000", bus.result); end
  endtask

  task automatic test_single_offset;
    reg_op_t exp_c;
    do_reset;
    @(negedge clk);
    bus.req_a[2] = 16'h1000; bus.req_b[2] = 8'h05; bus.req_mode[2] = MEMALU_OP_OFFSET; bus.req[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      exp_c = (k == 1) ? REG_OP_READ : (k == 2) ? REG_OP_WRITE : REG_OP_NONE;
      n_cmp++; if (bus.grant !== ((k <= 3) ? 3'b100 : 3'b000)) begin n_err++; $display("FAIL offset_grant c%0d got %b", k, bus.grant); end
      n_cmp++; if (bus.done !== ((k == 3) ? 3'b100 : 3'b000)) begin n_err++; $display("FAIL offset_done c%0d got %b", k, bus.done); end
      n_cmp++; if (bus.alu_control !== exp_c) begin n_err++; $display("FAIL offset_ctl c%0d got %0d want %0d", k, bus.alu_control, exp_c); end
      n_cmp++; if (bus.busy !== (k <= 3)) begin n_err++; $display("FAIL offset_busy c%0d got %b", k, bus.busy); end
      if (k == 3) begin
        n_cmp++; if (bus.result !== 16'h0F85) begin n_err++; $display("FAIL offset_result got %h want 0f85", bus.result); end
        bus.req[2] = 1'b0;
      end
    end
  endtask

  task automatic test_wrap;
    logic [15:0] res;
    int lat;
    do_reset;
    run_single(0, 16'hFFFF, 8'h00, MEMALU_OP_INCR, res, lat);
    n_cmp++; if (res !== 16'h0000 || lat != 3) begin n_err++; $display("FAIL wrap_incr got %h lat %0d want 0000 lat 3", res, lat); end
    run_single(1, 16'h0000, 8'h00, MEMALU_OP_DECR, res, lat);
    n_cmp++; if (res !== 16'hFFFF || lat != 3) begin n_err++; $display("FAIL wrap_decr got %h lat %0d want ffff lat 3", res, lat); end
    run_single(2, 16'hFFF0, 8'h20, MEMALU_OP_ADD, res, lat);
    n_cmp++; if (res !== 16'h0010 || lat != 3) begin n_err++; $display("FAIL wrap_add got %h lat %0d want 0010 lat 3", res, lat); end
  endtask

  task automatic test_contention;
    logic [2:0]  exp_d;
    logic [15:0] exp_r;
    do_reset;
    @(negedge clk);
    bus.req_a[0] = 16'h0100; bus.req_b[0] = 8'h00; bus.req_mode[0] = MEMALU_OP_INCR;
    bus.req_a[1] = 16'h0200; bus.req_b[1] = 8'h00; bus.req_mode[1] = MEMALU_OP_DECR;
    bus.req_a[2] = 16'h0300; bus.req_b[2] = 8'h33; bus.req_mode[2] = MEMALU_OP_ADD;
    bus.req = 3'b111;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk); #1;
      exp_d = (k == 3 || k == 12) ? 3'b001 : (k == 6) ? 3'b010 : (k == 9) ? 3'b100 : 3'b000;
      exp_r = (k == 3) ? 16'h0101 : (k == 6) ? 16'h01FF : (k == 9) ? 16'h0333 : 16'h8000;
      n_cmp++; if (bus.done !== exp_d) begin n_err++; $display("FAIL contend_done c%0d got %b want %b", k, bus.done, exp_d); end
      if (exp_d != 3'b000) begin
        n_cmp++; if (bus.result !== exp_r) begin n_err++; $display("FAIL contend_result c%0d got %h want %h", k, bus.result, exp_r); end
      end
      if (k == 3 || k == 12) bus.req[0] = 1'b0;
      if (k == 6) bus.req[1] = 1'b0;
      if (k == 9) bus.req[2] = 1'b0;
      if (k == 4) begin
        bus.req_a[0] = 16'h7FFF; bus.req_mode[0] = MEMALU_OP_INCR; bus.req[0] = 1'b1;
      end
    end
  endtask

  task automatic test_bus_stall;
    reg_op_t exp_c;
    do_reset;
    @(negedge clk);
    bus.req_a[0] = 16'h00FF; bus.req_b[0] = 8'h00; bus.req_mode[0] = MEMALU_OP_INCR; bus.req[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.bus_ok = 1'b0;
      if (k == 4) bus.bus_ok = 1'b1;
      #1;
      exp_c = (k == 1) ? REG_OP_READ : (k == 4) ? REG_OP_WRITE : REG_OP_NONE;
      n_cmp++; if (bus.alu_control !== exp_c) begin n_err++; $display("FAIL stall_ctl c%0d got %0d want %0d", k, bus.alu_control, exp_c); end
      n_cmp++; if (bus.done !== ((k == 5) ? 3'b001 : 3'b000)) begin n_err++; $display("FAIL stall_done c%0d got %b", k, bus.done); end
      if (k == 5) begin
        n_cmp++; if (bus.result !== 16'h0100) begin n_err++; $display("FAIL stall_result got %h want 0100", bus.result); end
        bus.req[0] = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_exec;
    logic [15:0] res;
    int lat;
    do_reset;
    @(negedge clk);
    bus.req_a[1] = 16'h4444; bus.req_b[1] = 8'h00; bus.req_mode[1] = MEMALU_OP_INCR; bus.req[1] = 1'b1;
    bus.bus_ok = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; bus.req[1] = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus.grant !== 3'b000 || bus.done !== 3'b000 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL abort_state got g=%b d=%b busy=%b want 000/000/0", bus.grant, bus.done, bus.busy);
    end
    n_cmp++; if (bus.alu_control !== REG_OP_NONE || bus.alu_a !== 16'h0 || bus.alu_mode !== MEMALU_OP_ADD) begin
      n_err++; $display("FAIL abort_alu got ctl=%0d a=%h mode=%0d want NONE/0000/ADD", bus.alu_control, bus.alu_a, bus.alu_mode);
    end
    rst = 1'b0; bus.bus_ok = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.done !== 3'b000 || bus.result !== 16'h0) begin n_err++; $display("FAIL abort_nodone got d=%b r=%h", bus.done, bus.result); end
    run_single(1, 16'h1234, 8'h00, MEMALU_OP_DECR, res, lat);
    n_cmp++; if (res !== 16'h1233 || lat != 3) begin n_err++; $display("FAIL abort_recover got %h lat %0d want 1233 lat 3", res, lat); end
  endtask

  task automatic test_operand_change;
    do_reset;
    @(negedge clk);
    bus.req_a[0] = 16'h1234; bus.req_b[0] = 8'h11; bus.req_mode[0] = MEMALU_OP_ADD; bus.req[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        bus.req_a[0] = 16'hAAAA; bus.req_b[0] = 8'hFF; bus.req_mode[0] = MEMALU_OP_DECR;
      end
    end
    n_cmp++; if (bus.done !== 3'b001 || bus.result !== 16'h1245) begin
      n_err++; $display("FAIL opchange got d=%b r=%h want 001/1245", bus.done, bus.result);
    end
    bus.req[0] = 1'b0;
  endtask

  task automatic test_random;
    logic [2:0] req_prev, done_prev, grant_prev, exp_g, g, d;
    logic [1:0] last_m;
    int n_done;
    do_reset;
    req_prev = 3'b000; done_prev = 3'b000; grant_prev = 3'b000; last_m = 2'd2; n_done = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      g = bus.grant;
      d = bus.done;
      exp_g = (grant_prev == 3'b000 || done_prev != 3'b000) ? rr_pick(req_prev & ~done_prev, last_m) : grant_prev;
      n_cmp++; if (g !== exp_g) begin n_err++; $display("FAIL rand_grant i%0d got %b want %b", i, g, exp_g); end
      if (d != 3'b000) begin
        n_cmp++; if (d !== g) begin n_err++; $display("FAIL rand_done i%0d got %b want %b", i, d, g); end
        for (int p = 0; p < 3; p++) begin
          if (d[p]) begin
            n_cmp++;
            if (bus.result !== alu_f(cur_a[p], cur_b[p], cur_m[p])) begin
              n_err++; $display("FAIL rand_result port %0d got %h want %h", p, bus.result, alu_f(cur_a[p], cur_b[p], cur_m[p]));
            end
            last_m = 2'(p);
            n_done++;
            if ($urandom_range(0, 1) == 1) present_op(p);
            else bus.req[p] = 1'b0;
          end
        end
      end
      for (int p = 0; p < 3; p++) begin
        if (!bus.req[p] && !d[p] && $urandom_range(0, 2) == 0) present_op(p);
        else if (g[p] && !d[p]) begin
          bus.req_a[p] = 16'($urandom); bus.req_b[p] = 8'($urandom);
          bus.req_mode[p] = memalu_op_t'($urandom_range(0, 3));
        end
      end
      bus.bus_ok = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++; if (bus.alu_control == REG_OP_WRITE && !bus.bus_ok) begin n_err++; $display("FAIL rand_write_without_bus i%0d", i); end
      req_prev = bus.req; done_prev = d; grant_prev = g;
    end
    n_cmp++; if (n_done < 50) begin n_err++; $display("FAIL rand_throughput got %0d completions want >=50", n_done); end
    bus.req = 3'b000;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req = 3'b000;
    bus.bus_ok = 1'b1;
    for (int p = 0; p < 3; p++) begin
      bus.req_a[p] = 16'h0; bus.req_b[p] = 8'h0; bus.req_mode[p] = MEMALU_OP_ADD;
      cur_a[p] = 16'h0; cur_b[p] = 8'h0; cur_m[p] = MEMALU_OP_ADD;
    end
    test_reset;
    test_single_offset;
    test_wrap;
    test_contention;
    test_bus_stall;
    test_reset_mid_exec;
    test_operand_change;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
